pipe_ex_stage: RTL and testbench

Execute stage of the 5-stage pipelined MIPS-like CPU. It takes decoded operands and control from the ID/EX boundary, performs the ALU operation, computes the branch target and destination register, and registers everything into the EX/MEM pipeline register for the mem stage. It also passes the debug instruction tag (type/number) forward one stage for the LCD trace.

---
 rtl/pipe_ex_stage_pkg.sv | 34 +++
 rtl/pipe_ex_stage_if.sv | 51 +++++
 rtl/pipe_ex_stage_ex_alu.sv | 34 +++
 rtl/pipe_ex_stage.sv | 72 +++++++
 tb/tb_pipe_ex_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ex_stage_pkg.sv
// Shared definitions for the execute stage: word width, ALU opcodes
// (also used by the ID-stage decoder) and the EX/MEM register layout.
package pipe_ex_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;

    // Everything the MEM stage receives from EX, registered as one word.
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              branch;
        logic [WORD_W-1:0] alu_r;
        logic [WORD_W-1:0] in_b;
        logic [4:0]        dest_r;
        logic [WORD_W-1:0] pc;
        logic              zero;
        logic [3:0]        ins_type;
        logic [3:0]        ins_number;
    } ex_mem_t;

endpackage

// File: rtl/pipe_ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled.
// master = surrounding pipeline (drives ID side), slave = EX stage.
interface pipe_ex_stage_if;
    import pipe_ex_stage_pkg::*;

    logic [WORD_W-1:0] id_imm;
    logic [WORD_W-1:0] id_inA;
    logic [WORD_W-1:0] id_inB;
    logic              id_wreg;
    logic              id_m2reg;
    logic              id_wmem;
    logic [3:0]        id_aluc;
    logic              id_aluimm;
    logic              id_shift;
    logic              id_branch;
    logic [WORD_W-1:0] id_pc4;
    logic              id_regrt;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [3:0]        in_ins_type;
    logic [3:0]        in_ins_number;

    logic              ex_wreg;
    logic              ex_m2reg;
    logic              ex_wmem;
    logic              ex_branch;
    logic [WORD_W-1:0] ex_aluR;
    logic [WORD_W-1:0] ex_inB;
    logic [4:0]        ex_destR;
    logic [WORD_W-1:0] ex_pc;
    logic              ex_zero;
    logic [3:0]        out_ins_type;
    logic [3:0]        out_ins_number;

    modport master (
        output id_imm, id_inA, id_inB, id_wreg, id_m2reg, id_wmem, id_aluc,
               id_aluimm, id_shift, id_branch, id_pc4, id_regrt, id_rt, id_rd,
               in_ins_type, in_ins_number,
        input  ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_aluR, ex_inB,
               ex_destR, ex_pc, ex_zero, out_ins_type, out_ins_number
    );

    modport slave (
        input  id_imm, id_inA, id_inB, id_wreg, id_m2reg, id_wmem, id_aluc,
               id_aluimm, id_shift, id_branch, id_pc4, id_regrt, id_rt, id_rd,
               in_ins_type, in_ins_number,
        output ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_aluR, ex_inB,
               ex_destR, ex_pc, ex_zero, out_ins_type, out_ins_number
    );

endinterface

// File: rtl/pipe_ex_stage_ex_alu.sv
// Combinational ALU for the execute stage. No overflow detection;
// unassigned opcodes produce 0.
module ex_alu
    import pipe_ex_stage_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [3:0]        aluc,
    output logic [WORD_W-1:0] r,
    output logic              zero
);

    // Opcode decode; shift amount is taken from the low 5 bits of A.
    always_comb begin
        r = '0;
        case (aluc)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: r = b << a[4:0];
            ALU_SRL: r = b >> a[4:0];
            ALU_SRA: r = $signed(b) >>> a[4:0];
            ALU_LUI: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
    end

    assign zero = (r == '0);

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage: operand selection, ALU, branch-target adder, destination
// mux, and the EX/MEM pipeline register (no stall/flush, loads every cycle).
module pipe_ex_stage
    import pipe_ex_stage_pkg::*;
#(
    parameter int DW = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ex_stage_if.slave    bus
);

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_r;
    logic          alu_zero;
    logic [DW-1:0] target;
    logic [4:0]    dest;
    ex_mem_t       ex_d;
    ex_mem_t       ex_q;

    // Operand muxes, branch target and destination select.
    always_comb begin
        alu_a  = bus.id_shift ? {27'b0, bus.id_imm[10:6]} : bus.id_inA;
        alu_b  = bus.id_aluimm ? bus.id_imm : bus.id_inB;
        target = bus.id_pc4 + (bus.id_imm << 2);
        dest   = bus.id_regrt ? bus.id_rt : bus.id_rd;
    end

    ex_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .aluc (bus.id_aluc),
        .r    (alu_r),
        .zero (alu_zero)
    );

    // Next EX/MEM contents; in_inB (not the muxed B) is kept as store data.
    always_comb begin
        ex_d            = '0;
        ex_d.wreg       = bus.id_wreg;
        ex_d.m2reg      = bus.id_m2reg;
        ex_d.wmem       = bus.id_wmem;
        ex_d.branch     = bus.id_branch;
        ex_d.alu_r      = alu_r;
        ex_d.in_b       = bus.id_inB;
        ex_d.dest_r     = dest;
        ex_d.pc         = target;
        ex_d.zero       = alu_zero;
        ex_d.ins_type   = bus.in_ins_type;
        ex_d.ins_number = bus.in_ins_number;
    end

    // EX/MEM register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.ex_wreg        = ex_q.wreg;
    assign bus.ex_m2reg       = ex_q.m2reg;
    assign bus.ex_wmem        = ex_q.wmem;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_aluR        = ex_q.alu_r;
    assign bus.ex_inB         = ex_q.in_b;
    assign bus.ex_destR       = ex_q.dest_r;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_zero        = ex_q.zero;
    assign bus.out_ins_type   = ex_q.ins_type;
    assign bus.out_ins_number = ex_q.ins_number;

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Bench for pipe_ex_stage: table of hand-computed vectors, expected
// results queued when driven and checked one edge later.
module tb_pipe_ex_stage;

    logic clk;
    logic rst;

    pipe_ex_stage_if bus ();

    pipe_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ina, inb, imm, pc4;
        logic [3:0]  aluc;
        logic        aluimm, shift, regrt;
        logic [4:0]  rt, rd;
        logic [3:0]  ctrl;   // {wreg, m2reg, wmem, branch}
        logic [3:0]  itype, inum;
        logic [31:0] exp_r;
        logic        exp_z;
        logic [4:0]  exp_dest;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] r, inb, pc;
        logic        z;
        logic [4:0]  dest;
        logic [3:0]  ctrl, itype, inum;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string n, logic [31:0] ina, logic [31:0] inb,
                                logic [31:0] imm, logic [31:0] pc4, logic [3:0] aluc,
                                logic aluimm, logic shift, logic regrt,
                                logic [4:0] rt, logic [4:0] rd, logic [3:0] ctrl,
                                logic [3:0] itype, logic [3:0] inum,
                                logic [31:0] er, logic ez, logic [4:0] ed, logic [31:0] ep);
        vec_t v;
        v.name = n; v.ina = ina; v.inb = inb; v.imm = imm; v.pc4 = pc4;
        v.aluc = aluc; v.aluimm = aluimm; v.shift = shift; v.regrt = regrt;
        v.rt = rt; v.rd = rd; v.ctrl = ctrl; v.itype = itype; v.inum = inum;
        v.exp_r = er; v.exp_z = ez; v.exp_dest = ed; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.id_inA = v.ina;   bus.id_inB = v.inb;   bus.id_imm = v.imm;
        bus.id_pc4 = v.pc4;   bus.id_aluc = v.aluc; bus.id_aluimm = v.aluimm;
        bus.id_shift = v.shift; bus.id_regrt = v.regrt;
        bus.id_rt = v.rt;     bus.id_rd = v.rd;
        {bus.id_wreg, bus.id_m2reg, bus.id_wmem, bus.id_branch} = v.ctrl;
        bus.in_ins_type = v.itype; bus.in_ins_number = v.inum;
    endtask

    // Expected register contents after the next edge for vector v.
    function automatic exp_t exp_of(vec_t v, bit in_reset);
        exp_t e;
        e.name = in_reset ? {v.name, "/rst"} : v.name;
        if (in_reset) begin
            e.r = '0; e.inb = '0; e.pc = '0; e.z = 1'b0; e.dest = '0;
            e.ctrl = '0; e.itype = '0; e.inum = '0;
        end else begin
            e.r = v.exp_r; e.inb = v.inb; e.pc = v.exp_pc; e.z = v.exp_z;
            e.dest = v.exp_dest; e.ctrl = v.ctrl; e.itype = v.itype; e.inum = v.inum;
        end
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".aluR"}, bus.ex_aluR, e.r);
        chk({e.name, ".zero"}, {31'b0, bus.ex_zero}, {31'b0, e.z});
        chk({e.name, ".destR"}, {27'b0, bus.ex_destR}, {27'b0, e.dest});
        chk({e.name, ".pc"}, bus.ex_pc, e.pc);
        chk({e.name, ".inB"}, bus.ex_inB, e.inb);
        chk({e.name, ".ctrl"},
            {28'b0, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_branch},
            {28'b0, e.ctrl});
        chk({e.name, ".ins"}, {24'b0, bus.out_ins_type, bus.out_ins_number},
            {24'b0, e.itype, e.inum});
    endtask

    // Apply one vector for one edge, then check the registered outputs.
    task automatic step(vec_t v, bit do_rst);
        drive(v);
        rst = do_rst;
        sb.push_back(exp_of(v, do_rst));
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //            name      inA           inB           imm           pc4        aluc  ai sh rt  rt  rd  ctrl    ty  no  expR          z  dest expPC
        vecs.push_back(mk("add",   32'd5,        32'd7,        32'd0,        32'h100,   4'h0, 0, 0, 0, 5'd9, 5'd3, 4'b1000, 1, 1, 32'd12,        0, 5'd3, 32'h100));
        vecs.push_back(mk("subi",  32'h10,       32'h55,       32'h10,       32'h200,   4'h1, 1, 0, 1, 5'd4, 5'd7, 4'b1100, 1, 2, 32'd0,         1, 5'd4, 32'h240));
        vecs.push_back(mk("wrap",  32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,     4'h0, 0, 0, 0, 5'd2, 5'd31,4'b0010, 3, 3, 32'd0,         1, 5'd31,32'h0));
        vecs.push_back(mk("sll",   32'd0,        32'h80000000, 32'h100,      32'h10,    4'h7, 0, 1, 0, 5'd1, 5'd6, 4'b1000, 0, 4, 32'd0,         1, 5'd6, 32'h410));
        vecs.push_back(mk("srl",   32'd0,        32'h80000000, 32'h100,      32'h10,    4'h8, 0, 1, 0, 5'd1, 5'd6, 4'b1000, 0, 4, 32'h08000000,  0, 5'd6, 32'h410));
        vecs.push_back(mk("sra",   32'd0,        32'h80000000, 32'h100,      32'h10,    4'h9, 0, 1, 0, 5'd1, 5'd6, 4'b1000, 0, 4, 32'hF8000000,  0, 5'd6, 32'h410));
        vecs.push_back(mk("sll1",  32'hFF,       32'd3,        32'h40,       32'h0,     4'h7, 0, 1, 0, 5'd1, 5'd5, 4'b1000, 0, 6, 32'd6,         0, 5'd5, 32'h100));
        vecs.push_back(mk("lui",   32'd0,        32'd0,        32'h1234,     32'h0,     4'hA, 1, 0, 1, 5'd8, 5'd0, 4'b1000, 4, 7, 32'h12340000,  0, 5'd8, 32'h48D0));
        vecs.push_back(mk("slt1",  32'hFFFFFFFF, 32'd1,        32'd0,        32'h20,    4'h6, 0, 0, 0, 5'd1, 5'd2, 4'b1000, 5, 8, 32'd1,         0, 5'd2, 32'h20));
        vecs.push_back(mk("slt0",  32'd1,        32'hFFFFFFFF, 32'd0,        32'h20,    4'h6, 0, 0, 0, 5'd1, 5'd2, 4'b1000, 5, 9, 32'd0,         1, 5'd2, 32'h20));
        vecs.push_back(mk("beq",   32'd3,        32'd3,        32'hFFFFFFFE, 32'h40,    4'h1, 0, 0, 0, 5'd0, 5'd0, 4'b0001, 2, 5, 32'd0,         1, 5'd0, 32'h38));
        vecs.push_back(mk("and",   32'hF0F0,     32'hFF00,     32'd0,        32'h80,    4'h2, 0, 0, 0, 5'd1, 5'd10,4'b1000, 6, 1, 32'h0000F000,  0, 5'd10,32'h80));
        vecs.push_back(mk("or",    32'hF0F0,     32'hFF00,     32'd0,        32'h80,    4'h3, 0, 0, 0, 5'd1, 5'd11,4'b1000, 6, 2, 32'h0000FFF0,  0, 5'd11,32'h80));
        vecs.push_back(mk("xor",   32'hF0F0,     32'hFF00,     32'd0,        32'h80,    4'h4, 0, 0, 0, 5'd1, 5'd12,4'b1000, 6, 3, 32'h00000FF0,  0, 5'd12,32'h80));
        vecs.push_back(mk("nor",   32'hF0F0,     32'hFF00,     32'd0,        32'h80,    4'h5, 0, 0, 0, 5'd1, 5'd13,4'b1000, 6, 4, 32'hFFFF000F,  0, 5'd13,32'h80));
        vecs.push_back(mk("opB",   32'd5,        32'd7,        32'd0,        32'h4,     4'hB, 0, 0, 0, 5'd1, 5'd14,4'b0100, 7, 1, 32'd0,         1, 5'd14,32'h4));
        vecs.push_back(mk("opF",   32'd5,        32'd7,        32'd0,        32'h8,     4'hF, 0, 0, 0, 5'd1, 5'd15,4'b0110, 7, 2, 32'd0,         1, 5'd15,32'h8));

        // Reset with nonzero inputs clears everything; releasing reset loads them.
        rst = 1'b1;
        step(vecs[0], 1'b1);
        step(vecs[0], 1'b0);

        // Back-to-back vectors, one per edge.
        foreach (vecs[i]) step(vecs[i], 1'b0);

        // Reset in the middle of traffic, then resume.
        step(vecs[10], 1'b1);
        step(vecs[10], 1'b0);

        // Same inputs twice: register must hold the same value, then change.
        v = vecs[7];
        step(v, 1'b0);
        step(v, 1'b0);
        step(vecs[4], 1'b0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
